// File: rtl/hamming_secded_dec_if.sv
// Bus bundle for the SEC-DED decoder stage: decode request, code word, counter
// clear, and the status/result signals returned to the peripheral.
interface hamming_secded_dec_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic [31:0]      code_in;
   logic             cnt_clr;
   logic             busy;
   logic             done;
   logic             res_wr;
   logic [31:0]      res_data;
   logic             err_any;
   logic [CNT_W-1:0] corr_cnt;
   logic [CNT_W-1:0] uncorr_cnt;

   modport master (
      output start, code_in, cnt_clr,
      input  busy, done, res_wr, res_data, err_any, corr_cnt, uncorr_cnt
   );

   modport slave (
      input  start, code_in, cnt_clr,
      output busy, done, res_wr, res_data, err_any, corr_cnt, uncorr_cnt
   );
endinterface

// File: rtl/hamming_secded_dec.sv
// Sequential SEC-DED decoder: four extended Hamming(8,4) codewords, one per
// cycle, then a one-cycle write of the packed result.
// Optional error counters are built only when HAMMING_ERR_CNT_EN is defined.
module hamming_secded_dec #(
   parameter int unsigned CNT_W = 16
) (
   input logic                clk,
   input logic                rst,
   hamming_secded_dec_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StDec, StWrite} state_e;

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] code_q, code_d;
   logic [23:0] acc_q, acc_d;
   logic [31:0] res_q, res_d;

   logic [7:0]  cw;
   logic [7:0]  fix;
   logic [2:0]  syn;
   logic        ov;
   logic        sgl;
   logic        dbl;
   logic [3:0]  nib;

   // Decode the codeword selected by idx_q from the shadow copy.
   always_comb begin
      cw = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (idx_q == 2'(i)) cw = code_q[8*i +: 8];
      end
      syn = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
             cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
             cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
      ov  = ^cw;
      sgl = ov;
      dbl = (syn != 3'd0) && !ov;
      fix = cw;
      // Syndrome points at the flipped bit (1-based); zero syndrome means c7.
      if (ov && (syn != 3'd0)) fix[syn - 3'd1] = ~cw[syn - 3'd1];
      nib = {fix[6], fix[5], fix[4], fix[2]};
   end

   // Next-state: latch on start, accumulate per codeword, publish on last one.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      code_d  = code_q;
      acc_d   = acc_q;
      res_d   = res_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StDec;
               idx_d   = 2'd0;
               code_d  = bus.code_in;
               acc_d   = 24'h0;
            end
         end
         StDec: begin
            for (int i = 0; i < 4; i++) begin
               if (idx_q == 2'(i)) begin
                  acc_d[4*i +: 4] = nib;
                  acc_d[16 + i]   = sgl;
                  acc_d[20 + i]   = dbl;
               end
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = StWrite;
               res_d   = {8'h00, acc_d};
            end
         end
         StWrite: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any partial decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 2'd0;
         code_q  <= 32'h0;
         acc_q   <= 24'h0;
         res_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StWrite);
   assign bus.res_wr   = (state_q == StWrite);
   assign bus.res_data = res_q;
   assign bus.err_any  = (state_q == StWrite) && (|res_q[23:16]);

`ifdef HAMMING_ERR_CNT_EN
   logic [CNT_W-1:0] corr_q, corr_d;
   logic [CNT_W-1:0] uncorr_q, uncorr_d;

   // Saturating error counters; clear wins over a same-cycle increment.
   always_comb begin
      corr_d   = corr_q;
      uncorr_d = uncorr_q;
      if (bus.cnt_clr) begin
         corr_d   = '0;
         uncorr_d = '0;
      end else if (state_q == StDec) begin
         if (sgl && (corr_q != '1))   corr_d   = corr_q + 1'b1;
         if (dbl && (uncorr_q != '1)) uncorr_d = uncorr_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else begin
         corr_q   <= corr_d;
         uncorr_q <= uncorr_d;
      end
   end

   assign bus.corr_cnt   = corr_q;
   assign bus.uncorr_cnt = uncorr_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = bus.cnt_clr;
   assign bus.corr_cnt   = {CNT_W{1'b0}};
   assign bus.uncorr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Self-checking bench for hamming_secded_dec: directed cases plus randomized
// words against a position-based Hamming reference model.
module tb_hamming_secded_dec;

   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   hamming_secded_dec_if #(.CNT_W(CNT_W)) bus ();

   hamming_secded_dec #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   int          phase  = 0;   // 0 idle, 1..4 decoding codeword phase-1, 5 write
   logic [31:0] m_code = '0;
   logic [31:0] m_res  = '0;
   int          m_corr = 0;
   int          m_unc  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Returns {double, single, data nibble}; the syndrome is the XOR of the
   // 1-based positions of all set bits among c[6:0].
   function automatic logic [5:0] cw_dec(input logic [7:0] c);
      int         s = 0;
      logic       p;
      logic [7:0] f = c;
      for (int j = 0; j < 7; j++) if (c[j]) s = s ^ (j + 1);
      p = ^c;
      if (p && s != 0) f[s-1] = ~f[s-1];
      return {(s != 0) && !p, p, f[6], f[5], f[4], f[2]};
   endfunction

   function automatic logic [31:0] word_dec(input logic [31:0] code);
      logic [31:0] r = '0;
      logic [5:0]  d;
      for (int i = 0; i < 4; i++) begin
         d = cw_dec(code[8*i +: 8]);
         r[4*i +: 4] = d[3:0];
         r[16 + i]   = d[4];
         r[20 + i]   = d[5];
      end
      return r;
   endfunction

   // Builds a clean codeword: parity bits are chosen so the position syndrome is 0.
   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [7:0] c = '0;
      int         s = 0;
      c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
      for (int j = 0; j < 7; j++) if (c[j]) s = s ^ (j + 1);
      if (s & 1) c[0] = 1'b1;
      if (s & 2) c[1] = 1'b1;
      if (s & 4) c[3] = 1'b1;
      c[7] = ^c[6:0];
      return c;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      logic [7:0]  c;
      int          k, a, b;
      for (int i = 0; i < 4; i++) begin
         c = encode(4'($urandom_range(0, 15)));
         k = $urandom_range(0, 2);
         a = $urandom_range(0, 7);
         b = (a + $urandom_range(1, 7)) % 8;
         if (k >= 1) c[a] = ~c[a];
         if (k == 2) c[b] = ~c[b];
         w[8*i +: 8] = c;
      end
      return w;
   endfunction

   // Advance the reference model across one rising edge using the sampled inputs.
   task automatic model_edge();
      logic [5:0] f;
      logic       clr;
      clr = bus.cnt_clr;
      if (phase == 0) begin
         if (bus.start) begin
            m_code = bus.code_in;
            phase  = 1;
         end
      end else if (phase <= 4) begin
         f = cw_dec(m_code[8*(phase-1) +: 8]);
`ifdef HAMMING_ERR_CNT_EN
         if (!clr) begin
            if (f[4] && m_corr < CNT_MAX) m_corr++;
            if (f[5] && m_unc  < CNT_MAX) m_unc++;
         end
`endif
         phase++;
         if (phase == 5) m_res = word_dec(m_code);
      end else begin
         phase = 0;
      end
`ifdef HAMMING_ERR_CNT_EN
      if (clr) begin
         m_corr = 0;
         m_unc  = 0;
      end
`else
      if (clr) f = 6'h0;
`endif
   endtask

   task automatic check_outputs();
      chk("busy",       32'(bus.busy),       32'(phase != 0));
      chk("done",       32'(bus.done),       32'(phase == 5));
      chk("res_wr",     32'(bus.res_wr),     32'(phase == 5));
      chk("err_any",    32'(bus.err_any),    32'((phase == 5) && (|m_res[23:16])));
      chk("res_data",   bus.res_data,        m_res);
      chk("corr_cnt",   32'(bus.corr_cnt),   32'(m_corr));
      chk("uncorr_cnt", 32'(bus.uncorr_cnt), 32'(m_unc));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic run_word(input logic [31:0] code, input logic [31:0] want, input string tag);
      bus.code_in = code;
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (4) step();
      chk(tag, bus.res_data, want);
      chk({tag, "_wr"}, 32'(bus.res_wr), 32'd1);
      step();
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && phase != 0; i++) step();
      chk("drain_idle", 32'(phase), 32'd0);
   endtask

   int pulses;
   int exp_corr;

   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.code_in = '0;
      bus.cnt_clr = 1'b0;
      #1;
      check_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // Directed words.
      run_word(32'h2D2D2D2D, 32'h0000_5555, "clean");
      run_word(32'h2D2D2D29, 32'h0001_5555, "single");
      run_word(32'h2E2D2D2D, 32'h0080_5555, "double");
      run_word(32'h7F0000FF, 32'h0008_F00F, "c7_err");

      // Saturation: four single errors per word.
      bus.cnt_clr = 1'b1;
      step();
      bus.cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) run_word(32'h29292929, 32'h000F_5555, "sat_word");
`ifdef HAMMING_ERR_CNT_EN
      exp_corr = CNT_MAX;
`else
      exp_corr = 0;
`endif
      chk("corr_sat", 32'(bus.corr_cnt), 32'(exp_corr));

      // Clear coinciding with an increment on the last codeword.
      bus.code_in = 32'h29292929;
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (3) step();
      bus.cnt_clr = 1'b1;
      step();
      bus.cnt_clr = 1'b0;
      chk("clr_prio", 32'(bus.corr_cnt), 32'd0);
      step();

      // start held high: writes in cycles 5, 11, 17; code change in cycle 2 ignored.
      pulses      = 0;
      bus.code_in = 32'h2D2D2D29;
      bus.start   = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         if (c == 2) bus.code_in = 32'hFFFF_FFFF;
         step();
         if (bus.res_wr) begin
            pulses++;
            chk("hold_cycle", 32'((c - 5) % 6), 32'd0);
         end
         if (c == 5) chk("hold_res0", bus.res_data, 32'h0001_5555);
      end
      chk("hold_pulses", 32'(pulses), 32'd3);
      bus.start = 1'b0;
      drain();

      // Reset during decoding, then a normal decode.
      bus.code_in = 32'h2D2D2D29;
      bus.start   = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      phase  = 0;
      m_res  = '0;
      m_corr = 0;
      m_unc  = 0;
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      run_word(32'h2E2D2D2D, 32'h0080_5555, "post_rst");

      // Randomized words with idle gaps, counter clears and mid-decode code changes.
      for (int n = 0; n < 150; n++) begin
         bus.code_in = rand_word();
         bus.start   = 1'b1;
         bus.cnt_clr = ($urandom_range(0, 15) == 0);
         step();
         bus.start = 1'b0;
         for (int c = 0; c < 5 + $urandom_range(0, 2); c++) begin
            bus.cnt_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) bus.code_in = $urandom;
            bus.start = ($urandom_range(0, 3) == 0);
            step();
         end
         bus.start   = 1'b0;
         bus.cnt_clr = 1'b0;
         drain();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
